// File: rtl/id_decode_queue.sv
// Instruction queue between fetch and decode: multi-slot enqueue, one registered decode slot out.
// Optional macro IDQ_BYPASS_EN lets slot 0 of a beat skip the empty queue straight into the output slot.
module id_decode_queue #(
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               if_valid,
  output logic                               if_ready,
  input  logic [$clog2(FETCH_W+1)-1:0]       if_num,
  input  logic [32*FETCH_W-1:0]              if_inst,
  input  logic [32*FETCH_W-1:0]              if_pc,
  output logic                               id_valid,
  input  logic                               id_ready,
  output logic [31:0]                        id_inst,
  output logic [31:0]                        id_pc,
  output logic [4:0]                         id_reg_d,
  output logic [4:0]                         id_reg_j,
  output logic [4:0]                         id_reg_k,
  output logic [25:0]                        id_imm,
  output logic [2:0]                         id_op_class,
  output logic                               id_is_branch,
  output logic                               id_ine,
  output logic [$clog2(DEPTH+1)-1:0]         idq_cnt
);

  localparam int unsigned NUM_W = $clog2(FETCH_W + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      mem_inst [DEPTH];
  logic [31:0]      mem_pc   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             accept;
  logic             q_empty;
  logic             slot_open;
  logic             deq;
  logic             bypass;
  logic             load;
  logic [NUM_W-1:0] enq_n;
  logic [31:0]      load_inst;
  logic [31:0]      load_pc;
  logic             dec_branch;
  logic [2:0]       dec_class;

  // Queue control; if_ready looks only at the current count so a dequeue never frees space the same cycle
  always_comb begin
    if_ready  = (CNT_W'(DEPTH) - idq_cnt >= CNT_W'(FETCH_W)) && !flush;
    accept    = if_valid && if_ready;
    q_empty   = (idq_cnt == '0);
    slot_open = !id_valid || id_ready;
    deq       = !q_empty && slot_open && !flush;
`ifdef IDQ_BYPASS_EN
    bypass    = accept && q_empty && slot_open;
`else
    bypass    = 1'b0;
`endif
    load      = deq || bypass;
    enq_n     = accept ? (if_num - NUM_W'(bypass)) : '0;
    load_inst = deq ? mem_inst[rd_ptr] : if_inst[31:0];
    load_pc   = deq ? mem_pc[rd_ptr]   : if_pc[31:0];
  end

  // Decode of the word about to enter the output slot
  always_comb begin
    dec_branch = (load_inst[31:26] >= 6'b010100) && (load_inst[31:26] <= 6'b011011);
    dec_class  = 3'd0;
    if (dec_branch)                                                   dec_class = 3'd1;
    else if (load_inst[31:28] == 4'b0001)                             dec_class = 3'd2;
    else if (load_inst[31:25] == 7'b0000001 ||
             load_inst[31:26] == 6'b001010)                           dec_class = 3'd3;
    else if (load_inst[31:20] == 12'h001)                             dec_class = 3'd4;
    else if (load_inst[31:24] == 8'h04)                               dec_class = 3'd5;
  end

  // Storage; a bypassed slot 0 shifts the remaining slots down by one
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < FETCH_W; i++) begin
        if (NUM_W'(i) < if_num && NUM_W'(i) >= NUM_W'(bypass)) begin
          mem_inst[PTR_W'(wr_ptr + PTR_W'(i) - PTR_W'(bypass))] <= if_inst[32*i +: 32];
          mem_pc[PTR_W'(wr_ptr + PTR_W'(i) - PTR_W'(bypass))]   <= if_pc[32*i +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      idq_cnt <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      idq_cnt <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PTR_W'(enq_n);
      rd_ptr  <= rd_ptr + PTR_W'(deq);
      idq_cnt <= idq_cnt + CNT_W'(enq_n) - CNT_W'(deq);
    end
  end

  // Output slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid     <= 1'b0;
      id_inst      <= '0;
      id_pc        <= '0;
      id_reg_d     <= '0;
      id_reg_j     <= '0;
      id_reg_k     <= '0;
      id_imm       <= '0;
      id_op_class  <= '0;
      id_is_branch <= 1'b0;
      id_ine       <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (load) begin
      id_valid     <= 1'b1;
      id_inst      <= load_inst;
      id_pc        <= load_pc;
      id_reg_d     <= load_inst[4:0];
      id_reg_j     <= load_inst[9:5];
      id_reg_k     <= load_inst[14:10];
      id_imm       <= {load_inst[9:0], load_inst[25:10]};
      id_op_class  <= dec_class;
      id_is_branch <= dec_branch;
      id_ine       <= (dec_class == 3'd0);
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_decode_queue.sv
// Randomized bench for id_decode_queue against a queue-level reference model, plus pinned literal cases.
module tb_id_decode_queue;

  localparam int FW  = 2;
  localparam int DEP = 8;
`ifdef IDQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          if_valid;
  logic          if_ready;
  logic [1:0]    if_num;
  logic [63:0]   if_inst;
  logic [63:0]   if_pc;
  logic          id_valid;
  logic          id_ready;
  logic [31:0]   id_inst;
  logic [31:0]   id_pc;
  logic [4:0]    id_reg_d;
  logic [4:0]    id_reg_j;
  logic [4:0]    id_reg_k;
  logic [25:0]   id_imm;
  logic [2:0]    id_op_class;
  logic          id_is_branch;
  logic          id_ine;
  logic [3:0]    idq_cnt;

  id_decode_queue #(.FETCH_W(FW), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .if_valid(if_valid), .if_ready(if_ready),
    .if_num(if_num), .if_inst(if_inst), .if_pc(if_pc), .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .id_reg_d(id_reg_d), .id_reg_j(id_reg_j), .id_reg_k(id_reg_k),
    .id_imm(id_imm), .id_op_class(id_op_class), .id_is_branch(id_is_branch), .id_ine(id_ine),
    .idq_cnt(idq_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t  q[$];
  logic  m_valid;
  ent_t  m_out;
  int    n_checks;
  int    n_fail;
  logic [31:0] pc_ctr;

  function automatic logic [2:0] ref_class(logic [31:0] w);
    if (w[31:26] >= 6'd20 && w[31:26] <= 6'd27) return 3'd1;
    if (w[31:28] == 4'h1) return 3'd2;
    if (w[31:25] == 7'd1 || w[31:26] == 6'd10) return 3'd3;
    if (w[31:20] == 12'h001) return 3'd4;
    if (w[31:24] == 8'h04) return 3'd5;
    return 3'd0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_out.inst = '0;
    m_out.pc = '0;
  endtask

  task automatic compare_all();
    int sz;
    logic [31:0] w;
    sz = q.size();
    check("if_ready", if_ready, ((DEP - sz >= FW) && !flush));
    check("idq_cnt", idq_cnt, sz);
    check("id_valid", id_valid, m_valid);
    if (m_valid) begin
      w = m_out.inst;
      check("id_inst", id_inst, w);
      check("id_pc", id_pc, m_out.pc);
      check("id_reg_d", id_reg_d, w[4:0]);
      check("id_reg_j", id_reg_j, w[9:5]);
      check("id_reg_k", id_reg_k, w[14:10]);
      check("id_imm", id_imm, {w[9:0], w[25:10]});
      check("id_op_class", id_op_class, ref_class(w));
      check("id_is_branch", id_is_branch, ref_class(w) == 3'd1);
      check("id_ine", id_ine, ref_class(w) == 3'd0);
    end
  endtask

  task automatic model_step();
    int   sz;
    bit   rdy_m, acc, open, byp;
    int   first;
    ent_t e;
    sz    = q.size();
    rdy_m = (DEP - sz >= FW) && !flush;
    acc   = if_valid && rdy_m;
    first = 0;
    if (flush) begin
      q.delete();
      m_valid = 1'b0;
    end else begin
      open = !m_valid || id_ready;
      byp  = BYP && acc && sz == 0 && open;
      if (open && sz > 0) begin
        m_out = q.pop_front();
        m_valid = 1'b1;
      end else if (byp) begin
        m_out.inst = if_inst[31:0];
        m_out.pc = if_pc[31:0];
        m_valid = 1'b1;
        first = 1;
      end else if (id_ready) begin
        m_valid = 1'b0;
      end
      if (acc) begin
        for (int i = first; i < int'(if_num); i++) begin
          e.inst = if_inst[32*i +: 32];
          e.pc = if_pc[32*i +: 32];
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic do_cycle(input logic v, input logic [1:0] num, input logic [63:0] insts,
                          input logic [63:0] pcs, input logic rdy, input logic fl);
    @(negedge clk);
    if_valid = v;
    if_num = num;
    if_inst = insts;
    if_pc = pcs;
    id_ready = rdy;
    flush = fl;
    #1;
    compare_all();
    model_step();
    @(posedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: w[31:26] = 6'(20 + $urandom_range(0, 7));
      1: w[31:28] = 4'h1;
      2: w[31:25] = 7'd1;
      3: w[31:26] = 6'd10;
      4: w[31:20] = 12'h001;
      5: w[31:24] = 8'h04;
      default: w = 32'hFFFFFFFF;
    endcase
    return w;
  endfunction

  initial begin
    n_checks = 0;
    n_fail = 0;
    pc_ctr = 32'h1c00_0100;
    rst_n = 1'b0;
    flush = 1'b0;
    if_valid = 1'b0;
    if_num = 2'd0;
    if_inst = '0;
    if_pc = '0;
    id_ready = 1'b0;
    model_reset();
    #3;
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_idq_cnt", idq_cnt, 4'd0);
    check("rst_id_inst", id_inst, 32'h0);
    check("rst_if_ready", if_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Two-slot beat: a 2RI12 word then a branch, emerging in order
    do_cycle(1'b1, 2'd2, {32'h50000400, 32'h02800421}, {32'h1c000004, 32'h1c000000}, 1'b1, 1'b0);
    #2;
    check("lat_valid_t", id_valid, BYP);
    do_cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
    #2;
    check("first_valid", id_valid, 1'b1);
    check("first_inst", id_inst, BYP ? 32'h50000400 : 32'h02800421);
    if (!BYP) begin
      check("first_class", id_op_class, 3'd3);
      check("first_imm", id_imm, 26'h021A001);
      check("first_pc", id_pc, 32'h1c000000);
    end
    do_cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
    #2;
    if (!BYP) begin
      check("second_inst", id_inst, 32'h50000400);
      check("second_branch", id_is_branch, 1'b1);
      check("second_class", id_op_class, 3'd1);
    end
    do_cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
    do_cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);

    // Undecodable word still presented, flagged ine
    do_cycle(1'b1, 2'd1, {32'h0, 32'hFFFFFFFF}, {32'h0, 32'h1c000040}, 1'b1, 1'b0);
    if (!BYP) do_cycle(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    #2;
    check("ine_valid", id_valid, 1'b1);
    check("ine_class", id_op_class, 3'd0);
    check("ine_flag", id_ine, 1'b1);
    do_cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
    do_cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);

    // Stalled fill: output holds the first word, count saturates at 7 with FW=2
    for (int b = 0; b < 5; b++) begin
      do_cycle(1'b1, 2'd2, {rand_inst(), 32'h02800000 + 32'(b)}, {pc_ctr + 32'd4, pc_ctr}, 1'b0, 1'b0);
      pc_ctr += 32'd8;
    end
    #2;
    check("fill_cnt", idq_cnt, 4'd7);
    check("fill_ready", if_ready, 1'b0);
    check("fill_hold", id_inst, 32'h02800000);

    // Flush with a beat offered drops everything
    do_cycle(1'b1, 2'd2, {rand_inst(), rand_inst()}, {pc_ctr + 32'd4, pc_ctr}, 1'b1, 1'b1);
    #2;
    check("flush_cnt", idq_cnt, 4'd0);
    check("flush_valid", id_valid, 1'b0);

    // Random traffic with one asynchronous reset mid-stream
    for (int n = 0; n < 3000; n++) begin
      logic v, r, f;
      logic [1:0] num;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 40) == 0);
      num = 2'($urandom_range(1, 2));
      do_cycle(v, num, {rand_inst(), rand_inst()}, {pc_ctr + 32'd4, pc_ctr}, r, f);
      pc_ctr += 32'd8;
      if (n == 1500) begin
        @(negedge clk);
        if_valid = 1'b0;
        flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", id_valid, 1'b0);
        check("arst_cnt", idq_cnt, 4'd0);
        check("arst_inst", id_inst, 32'h0);
        check("arst_class", id_op_class, 3'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
